hb_decimator: RTL and testbench

- Rx-side counterpart of the Tx half-band interpolator: 11-tap half-band FIR decimating by 2 on a single clock domain, with sample-valid strobes on input and output.
- Sits after the Rx CIC/decimation chain and feeds baseband processing.
- Polyphase implementation: the odd branch is the centre tap only, so one output is produced per two accepted input samples.
- Output must be bit-exact to the arithmetic model defined below.

---
 rtl/hb_decimator.sv | 84 ++++++++
 tb/tb_hb_decimator.sv | 134 +++++++++++++
 2 files changed

// File: rtl/hb_decimator.sv
// hb_decimator: 11-tap half-band FIR, decimate-by-2, symmetric pre-add,
// round-half-up and saturate, one registered output per odd-indexed input.
`default_nettype none

module hb_decimator #(
   parameter int IN_W      = 16,
   parameter int OUT_W     = 16,
   parameter int COEF_W    = 16,
   parameter int COEF_FRAC = 15,
   parameter int H0        = 324,
   parameter int H2        = -1874,
   parameter int H4        = 9741,
   parameter int HC        = 16384
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic signed [IN_W-1:0]  in_data,
   output logic                    out_valid,
   output logic signed [OUT_W-1:0] out_data
);

   localparam int ACC_W = IN_W + COEF_W + 3;
   localparam int PRE_W = IN_W + 1;

   localparam logic signed [COEF_W-1:0] C0 = COEF_W'(H0);
   localparam logic signed [COEF_W-1:0] C2 = COEF_W'(H2);
   localparam logic signed [COEF_W-1:0] C4 = COEF_W'(H4);
   localparam logic signed [COEF_W-1:0] CC = COEF_W'(HC);

   localparam logic signed [ACC_W-1:0] RND     = ACC_W'(1) << (COEF_FRAC - 1);
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

   // dl[i] holds x[n-1-i] relative to the sample currently on in_data
   logic signed [IN_W-1:0]  dl [0:9];
   logic                    phase;

   logic signed [PRE_W-1:0] s0, s2, s4;
   logic signed [ACC_W-1:0] acc, rnd, shifted, sat;

   always_comb begin
      s0 = PRE_W'(in_data) + PRE_W'(dl[9]);
      s2 = PRE_W'(dl[1])   + PRE_W'(dl[7]);
      s4 = PRE_W'(dl[3])   + PRE_W'(dl[5]);
      acc = ACC_W'(s0) * ACC_W'(C0)
          + ACC_W'(s2) * ACC_W'(C2)
          + ACC_W'(s4) * ACC_W'(C4)
          + ACC_W'(dl[4]) * ACC_W'(CC);
      rnd     = acc + RND;
      shifted = rnd >>> COEF_FRAC;
      if (shifted > SAT_MAX) begin
         sat = SAT_MAX;
      end else if (shifted < SAT_MIN) begin
         sat = SAT_MIN;
      end else begin
         sat = shifted;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 10; i++) dl[i] <= '0;
         phase     <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         out_valid <= 1'b0;
         if (in_valid) begin
            dl[0] <= in_data;
            for (int i = 1; i < 10; i++) dl[i] <= dl[i-1];
            phase <= ~phase;
            // phase=1 means the sample being accepted is odd-indexed
            if (phase) begin
               out_valid <= 1'b1;
               out_data  <= OUT_W'(sat);
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_hb_decimator.sv
// Directed bench for hb_decimator: hand-computed outputs, latency and gap checks.
`default_nettype none

module tb_hb_decimator;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               in_valid = 1'b0;
   logic signed [15:0] in_data = '0;
   logic               out_valid;
   logic signed [15:0] out_data;

   int checks = 0;
   int failures = 0;
   int idx = 0;
   int last_out = 0;
   int out_q[$];
   int exp_q[$];

   hb_decimator dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_data  (out_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic do_reset(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         rst = 1'b1; in_valid = 1'b1; in_data = 16'sd1234;
         @(posedge clk); #1;
         chk("rst_out_valid", int'(out_valid), 0);
         chk("rst_out_data", int'(out_data), 0);
      end
      rst = 1'b0; in_valid = 1'b0; in_data = '0;
      idx = 0; last_out = 0;
      out_q.delete();
   endtask

   task automatic send(input int x);
      in_valid = 1'b1; in_data = 16'(x);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("latency_valid", int'(out_valid), idx % 2);
      if (out_valid === 1'b1) begin
         last_out = int'(out_data);
         out_q.push_back(last_out);
      end
      idx++;
   endtask

   task automatic gap();
      in_valid = 1'b0; in_data = 16'($urandom);
      @(posedge clk); #1;
      chk("gap_valid", int'(out_valid), 0);
      chk("gap_hold", int'(out_data), last_out);
   endtask

   task automatic compare(input string tag);
      chk({tag, "_count"}, out_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < out_q.size()) chk($sformatf("%s_y%0d", tag, i), out_q[i], exp_q[i]);
      end
   endtask

   task automatic even_impulse();
      send(1000);
      for (int i = 1; i < 12; i++) send(0);
      exp_q = '{0, 0, 500, 0, 0, 0};
      compare("even_imp");
   endtask

   initial begin
      int pat[12];
      @(posedge clk); #1;

      do_reset(3);
      even_impulse();

      do_reset(1);
      send(0); send(1000);
      for (int i = 2; i < 16; i++) send(0);
      exp_q = '{10, -57, 297, 297, -57, 10, 0, 0};
      compare("odd_imp");

      do_reset(1);
      for (int i = 0; i < 20; i++) send(10000);
      exp_q = '{99, -473, 7500, 10472, 9901, 9999, 9999, 9999, 9999, 9999};
      compare("dc");

      do_reset(1);
      for (int i = 0; i < 20; i++) begin
         while ($urandom_range(0, 1) == 1) gap();
         send(10000);
         gap();
      end
      compare("dc_gaps");

      pat = '{0, 32767, 0, -32768, 0, 32767, 32767, 32767, 0, -32768, 0, 32767};
      do_reset(1);
      for (int i = 0; i < 12; i++) send(pat[i]);
      chk("sat_pos_count", out_q.size(), 6);
      if (out_q.size() == 6) chk("sat_pos_y5", out_q[5], 32767);

      do_reset(1);
      for (int i = 0; i < 12; i++) send(pat[i] == 32767 ? -32768 : (pat[i] == -32768 ? 32767 : 0));
      chk("sat_neg_count", out_q.size(), 6);
      if (out_q.size() == 6) chk("sat_neg_y5", out_q[5], -32768);

      do_reset(1);
      for (int i = 0; i < 16; i++) send(10000);
      chk("pre_rst_count", out_q.size(), 8);
      chk("pre_rst_last", last_out, 9999);
      do_reset(1);
      even_impulse();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
